apa102_frame_sequencer: RTL and testbench

APA102_FRAME_SEQUENCER -- requirements
Module: apa102_frame_sequencer

---
 rtl/apa102_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_apa102_frame_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_frame_sequencer.sv
// apa102_frame_sequencer
//   Streams one complete APA102 frame per accepted start: a 32-bit zero start
//   frame, then one 32-bit LED frame per pixel, then END_BITS one-bits.
//   Pixel colours are fetched one at a time through a request/valid handshake.
//   The serial clock stays parked low while a fetch is outstanding.
// Ports
//   CLK        system clock, rising-edge
//   my_reset   asynchronous active-high reset
//   start      one-cycle frame request; honoured only when idle
//   brightness 5-bit global brightness, latched when start is accepted
//   pix_req    pixel fetch request, held until pix_valid
//   pix_addr   LED index being fetched
//   pix_valid  pixel data valid; completes the fetch
//   pix_rgb    pixel colour {R, G, B}
//   mosi/sck   serial data / clock to the strip
//   busy       high from accepted start until return to idle
//   done       one-cycle pulse when the last end-frame bit completes
module apa102_frame_sequencer #(
  parameter int NUM_LEDS = 60,
  parameter int CLK_DIV  = 4
) (
  input  logic        CLK,
  input  logic        my_reset,
  input  logic        start,
  input  logic [4:0]  brightness,
  output logic        pix_req,
  output logic [9:0]  pix_addr,
  input  logic        pix_valid,
  input  logic [23:0] pix_rgb,
  output logic        mosi,
  output logic        sck,
  output logic        busy,
  output logic        done
);

  localparam int END_BITS = ((NUM_LEDS + 15) / 16) * 8;
  localparam int MAX_BITS = (END_BITS > 32) ? END_BITS : 32;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] LAST_WORD_BIT = CW'(31);
  localparam logic [CW-1:0] LAST_END_BIT  = CW'(END_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST      = DW'(CLK_DIV - 1);
  localparam logic [9:0]    LAST_LED      = 10'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE, START_FRAME, FETCH, LED_FRAME, END_FRAME
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [31:0]     sh_q;       // current bit is always sh_q[31]
  logic [4:0]      bright_q;
  logic [9:0]      idx_q;
  logic            pix_req_q, mosi_q, sck_q, busy_q, done_q;
  logic            bit_last;

  assign pix_req  = pix_req_q;
  assign pix_addr = idx_q;
  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // The end frame can be longer than 32 bits; the other frames are one word.
  assign bit_last = (state_q == END_FRAME) ? (bit_cnt_q == LAST_END_BIT)
                                           : (bit_cnt_q == LAST_WORD_BIT);

  always_ff @(posedge CLK or posedge my_reset) begin
    if (my_reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      bright_q  <= '0;
      idx_q     <= '0;
      pix_req_q <= 1'b0;
      mosi_q    <= 1'b0;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bright_q  <= brightness;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            sh_q      <= '0;
            mosi_q    <= 1'b0;
            sck_q     <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= START_FRAME;
          end
        end

        START_FRAME, LED_FRAME, END_FRAME: begin
          // Each bit: CLK_DIV cycles low (mosi already set), then CLK_DIV
          // high. mosi only moves on the same edge that drops sck, so it is
          // stable across every rising edge.
          if (div_q != DIV_LAST) begin
            div_q <= div_q + DW'(1);
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              if (!bit_last) begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
                sh_q      <= {sh_q[30:0], 1'b0};
                mosi_q    <= (state_q == END_FRAME) | sh_q[30];
              end else begin
                bit_cnt_q <= '0;
                if (state_q == START_FRAME) begin
                  // mosi keeps the last shifted bit while fetching
                  pix_req_q <= 1'b1;
                  state_q   <= FETCH;
                end else if (state_q == LED_FRAME) begin
                  if (idx_q < LAST_LED) begin
                    idx_q     <= idx_q + 10'd1;
                    pix_req_q <= 1'b1;
                    state_q   <= FETCH;
                  end else begin
                    mosi_q  <= 1'b1;
                    state_q <= END_FRAME;
                  end
                end else begin
                  mosi_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                end
              end
            end
          end
        end

        FETCH: begin
          // pix_req is high exactly while in FETCH, so a stray pix_valid
          // in any other state falls through untouched.
          if (pix_valid) begin
            pix_req_q <= 1'b0;
            sh_q      <= {3'b111, bright_q, pix_rgb[7:0], pix_rgb[15:8], pix_rgb[23:16]};
            mosi_q    <= 1'b1;
            div_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= LED_FRAME;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apa102_frame_sequencer.sv
module tb_apa102_frame_sequencer;

  localparam int NLED = 2;
  localparam int CDIV = 2;
  localparam int EDGES = 32 + 32 * NLED + 8;

  logic        CLK = 1'b0;
  logic        my_reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  brightness = '0;
  logic        pix_req;
  logic [9:0]  pix_addr;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic        mosi, sck, busy, done;

  apa102_frame_sequencer #(.NUM_LEDS(NLED), .CLK_DIV(CDIV)) dut (
    .CLK(CLK), .my_reset(my_reset), .start(start), .brightness(brightness),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid),
    .pix_rgb(pix_rgb), .mosi(mosi), .sck(sck), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  br;
    logic [23:0] rgb0, rgb1;
    int          d0, d1;
    bit          inj;
    bit          noise;
    logic [31:0] w0, w1;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  // monitor / responder state
  bit          cap[$];
  int          done_cnt, fetch_bad, hold_bad, busy_bad;
  int          flen[2];
  logic [23:0] rgb_tab[2];
  int          dly_tab[2];
  bit          noise;
  logic        sck_prev, mosi_prev, req_prev, fm;
  logic [9:0]  fa;
  int          wcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Model of one LED word: header, brightness, then B, G, R.
  function automatic logic [31:0] led_word(input logic [4:0] br, input logic [23:0] rgb);
    return {3'b111, br, rgb[7:0], rgb[15:8], rgb[23:16]};
  endfunction

  // Samples away from the rising CLK edge; also plays the pixel source.
  always @(negedge CLK) begin
    if (my_reset) begin
      sck_prev = 1'b0; mosi_prev = 1'b0; req_prev = 1'b0;
      wcnt = 0; pix_valid = 1'b0;
    end else begin
      if (sck && !sck_prev) cap.push_back(mosi);
      if (sck && sck_prev && mosi != mosi_prev) hold_bad++;
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
      end
      if (pix_req) begin
        if (!req_prev) begin fa = pix_addr; fm = mosi; end
        if (sck || pix_addr != fa || mosi != fm) fetch_bad++;
        if (pix_addr < 2) flen[pix_addr[0]]++;
        if (pix_addr < 2 && wcnt == dly_tab[pix_addr[0]]) begin
          pix_valid = 1'b1;
          pix_rgb = rgb_tab[pix_addr[0]];
        end else begin
          pix_valid = 1'b0;
        end
        wcnt++;
      end else begin
        wcnt = 0;
        pix_valid = noise && ($urandom_range(0, 2) == 0);
        pix_rgb = 24'($urandom);
      end
      sck_prev = sck; mosi_prev = mosi; req_prev = pix_req;
    end
  end

  task automatic clear_mon();
    cap.delete();
    done_cnt = 0; fetch_bad = 0; hold_bad = 0; busy_bad = 0;
    flen[0] = 0; flen[1] = 0;
  endtask

  task automatic run_frame(input string name, input vec_t v);
    logic [31:0] hdr, w0, w1;
    logic [7:0]  tail;
    bit          injd;
    int          n;
    rgb_tab[0] = v.rgb0; rgb_tab[1] = v.rgb1;
    dly_tab[0] = v.d0;   dly_tab[1] = v.d1;
    noise = v.noise;
    injd = 0;
    @(negedge CLK); #1;
    clear_mon();
    brightness = v.br; start = 1'b1;
    @(negedge CLK); #1;
    start = 1'b0;
    brightness = 5'($urandom);     // must already be latched
    chk({name, "_busy_start"}, 64'(busy), 64'd1);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge CLK); #1;
      if (v.inj && !injd && cap.size() >= 40) begin
        start = 1'b1; brightness = 5'h00; injd = 1;
      end else begin
        start = 1'b0;
      end
      n++;
    end
    start = 1'b0;
    repeat (20) @(negedge CLK);
    #1;
    chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({name, "_edges"}, 64'(cap.size()), 64'(EDGES));
    if (cap.size() >= EDGES) begin
      hdr = '0; w0 = '0; w1 = '0; tail = '0;
      for (int i = 0; i < 32; i++) begin
        hdr = {hdr[30:0], cap[i]};
        w0  = {w0[30:0], cap[32 + i]};
        w1  = {w1[30:0], cap[64 + i]};
      end
      for (int i = 0; i < 8; i++) tail = {tail[6:0], cap[96 + i]};
      chk({name, "_start_frame"}, 64'(hdr), 64'h0);
      chk({name, "_led0"}, 64'(w0), 64'(v.w0));
      chk({name, "_led1"}, 64'(w1), 64'(v.w1));
      chk({name, "_end_frame"}, 64'(tail), 64'hFF);
    end
    chk({name, "_idle_busy_sck_mosi"}, 64'({busy, sck, mosi}), 64'd0);
    chk({name, "_busy_at_done"}, 64'(busy_bad), 64'd0);
    chk({name, "_fetch_stable"}, 64'(fetch_bad), 64'd0);
    chk({name, "_mosi_hold"}, 64'(hold_bad), 64'd0);
    chk({name, "_fetch0_len"}, 64'(flen[0]), 64'(v.d0 + 1));
    chk({name, "_fetch1_len"}, 64'(flen[1]), 64'(v.d1 + 1));
  endtask

  vec_t tab[6];
  vec_t rv;

  initial begin
    int n;
    tab[0] = '{5'h1F, 24'hFF0000, 24'h00FF00, 0, 0,  0, 0, 32'hFF0000FF, 32'hFF00FF00};
    tab[1] = '{5'h1F, 24'hFF0000, 24'h00FF00, 0, 50, 0, 0, 32'hFF0000FF, 32'hFF00FF00};
    tab[2] = '{5'h1F, 24'hFF0000, 24'h00FF00, 0, 0,  1, 0, 32'hFF0000FF, 32'hFF00FF00};
    tab[3] = '{5'h00, 24'h123456, 24'hABCDEF, 2, 1,  0, 1, 32'hE0563412, 32'hE0EFCDAB};
    tab[4] = '{5'h0A, 24'hABCDEF, 24'h000000, 1, 3,  0, 1, 32'hEAEFCDAB, 32'hEA000000};
    tab[5] = '{5'h15, 24'hFFFFFF, 24'h000001, 0, 0,  1, 1, 32'hF5FFFFFF, 32'hF5010000};
    noise = 0;
    dly_tab[0] = 0; dly_tab[1] = 0;
    rgb_tab[0] = '0; rgb_tab[1] = '0;

    // asynchronous reset, before any clock edge
    #1 my_reset = 1'b1;
    #1;
    chk("rst_sck_mosi", 64'({sck, mosi}), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_pix", 64'({pix_req, pix_addr}), 64'd0);
    repeat (3) @(negedge CLK);
    my_reset = 1'b0;
    repeat (2) @(negedge CLK);
    #1 chk("idle_after_rst", 64'({busy, sck, mosi, pix_req}), 64'd0);

    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), tab[i]);

    // reset inside LED frame of index 0, while sck is high and mosi is 1
    rgb_tab[0] = 24'hFF0000; rgb_tab[1] = 24'h00FF00;
    dly_tab[0] = 0; dly_tab[1] = 0; noise = 0;
    @(negedge CLK); #1;
    clear_mon();
    brightness = 5'h1F; start = 1'b1;
    @(negedge CLK); #1;
    start = 1'b0;
    n = 0;
    while (!(cap.size() >= 34 && sck) && n < 1000) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("pre_rst_sck_mosi_busy", 64'({sck, mosi, busy}), 64'h7);
    my_reset = 1'b1;
    #1;
    chk("mid_rst_sck_mosi_busy", 64'({sck, mosi, busy}), 64'h0);
    chk("mid_rst_pix_req", 64'(pix_req), 64'd0);
    repeat (3) @(negedge CLK);
    my_reset = 1'b0;
    repeat (30) @(negedge CLK);
    #1;
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    chk("mid_rst_stays_idle", 64'({busy, sck, pix_req}), 64'd0);
    run_frame("post_rst", tab[0]);

    // randomized frames against the word model
    for (int k = 0; k < 6; k++) begin
      rv.br = 5'($urandom);
      rv.rgb0 = 24'($urandom);
      rv.rgb1 = 24'($urandom);
      rv.d0 = $urandom_range(0, 6);
      rv.d1 = $urandom_range(0, 6);
      rv.inj = 1'($urandom);
      rv.noise = 1;
      rv.w0 = led_word(rv.br, rv.rgb0);
      rv.w1 = led_word(rv.br, rv.rgb1);
      run_frame($sformatf("rnd%0d", k), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
